// File: rtl/key_sw_conditioner_if.sv
// rtl/key_sw_conditioner_if.sv - Raw key/switch inputs and conditioned outputs.
interface key_sw_conditioner_if #(
  parameter int NKEY = 4,
  parameter int NSW  = 18
);
  logic [NKEY-1:0] KEY;
  logic [NSW-1:0]  sw;
  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_press;
  logic [NKEY-1:0] key_release;
  logic [NSW-1:0]  sw_sync;

  modport master (
    output KEY, sw,
    input  key_level, key_press, key_release, sw_sync
  );

  modport slave (
    input  KEY, sw,
    output key_level, key_press, key_release, sw_sync
  );
endinterface

// File: rtl/key_sw_conditioner.sv
// rtl/key_sw_conditioner.sv - Synchronizes DE2 keys/switches and debounces each key.
module key_sw_conditioner #(
  parameter int NKEY            = 4,
  parameter int NSW             = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  key_sw_conditioner_if.slave   io
);

  typedef enum logic [1:0] {IDLE, PWAIT, PRESSED, RWAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEY-1:0]  k_meta, k_sync, ksync;
  logic [NSW-1:0]   s_meta, s_sync;
  state_t           state_q [NKEY];
  state_t           state_d [NKEY];
  logic [CNT_W-1:0] cnt_q   [NKEY];
  logic [CNT_W-1:0] cnt_d   [NKEY];
  logic [NKEY-1:0]  level_q, press_q, release_q;
  logic [NKEY-1:0]  level_d, press_d, release_d;

  // Key synchronizers reset to "released" so nothing debounces out of reset.
  assign ksync = ~k_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_meta    <= '1;
      k_sync    <= '1;
      s_meta    <= '0;
      s_sync    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NKEY; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      k_meta    <= io.KEY;
      k_sync    <= k_meta;
      s_meta    <= io.sw;
      s_sync    <= s_meta;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NKEY; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NKEY; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (ksync[i]) begin
            state_d[i] = PWAIT;
            cnt_d[i]   = '0;
          end
        end
        PWAIT: begin
          if (!ksync[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!ksync[i]) begin
            state_d[i] = RWAIT;
            cnt_d[i]   = '0;
          end
        end
        RWAIT: begin
          if (ksync[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      // Outputs are registered from the next state so they align with the state flop.
      level_d[i]   = (state_d[i] == PRESSED) || (state_d[i] == RWAIT);
      press_d[i]   = (state_q[i] == PWAIT) && (state_d[i] == PRESSED);
      release_d[i] = (state_q[i] == RWAIT) && (state_d[i] == IDLE);
    end
  end

  assign io.key_level   = level_q;
  assign io.key_press   = press_q;
  assign io.key_release = release_q;
  assign io.sw_sync     = s_sync;

endmodule

// File: doc/key_sw_conditioner.md
Name: key_sw_conditioner

Overview:
- Input-side partner of the counter/display path: DE2 push buttons and slide switches enter here; the counter consumes the outputs.
- Synchronizes the raw KEY[3:0] (active-low) and sw[17:0] inputs into the clk domain.
- Debounces each key independently with a 4-state FSM.
- Outputs a clean level per key, plus one-cycle press and release pulses, for the counter logic.

Parameters:
- NKEY, 4, number of push buttons.
- NSW, 18, number of slide switches.
- DEBOUNCE_CYCLES, 500000, stable cycles required before a key change is accepted (10 ms at 50 MHz). Must be at least 2.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- KEY  in  NKEY  raw push buttons, active-low (0 = pressed), asynchronous.
- sw  in  NSW  raw slide switches, asynchronous.
- key_level  out  NKEY  debounced key state, active-high (1 = pressed).
- key_press  out  NKEY  one-cycle pulse on an accepted press.
- key_release  out  NKEY  one-cycle pulse on an accepted release.
- sw_sync  out  NSW  2-flop synchronized switches, no debounce.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, sampled only at the rising edge of clk.
- Reset values:
  - KEY synchronizer flops = all 1 (released).
  - sw synchronizer flops = 0.
  - All FSMs in IDLE, all counters = 0.
  - key_level, key_press, key_release = 0; sw_sync = 0.
- Synchronizer: 2 flops per bit. ksync = synchronized KEY inverted, so 1 = pressed. ksync and sw_sync reflect the raw input 2 edges after it is first sampled.
- Per-key FSM (identical, independent instance for each i), all transitions registered:
  - IDLE: key_level=0. If ksync[i]=1 -> PWAIT with cnt=0.
  - PWAIT: key_level=0.
    - If ksync[i]=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
    - Else cnt++.
  - PRESSED: key_level=1. If ksync[i]=0 -> RWAIT with cnt=0.
  - RWAIT: key_level=1.
    - If ksync[i]=1 -> PRESSED, cnt=0 (no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Else cnt++.
- Pulses:
  - key_press[i] is registered and high for exactly the first cycle in which the state is PRESSED after a PWAIT->PRESSED transition.
  - key_release[i] is high for exactly the first cycle of IDLE after RWAIT->IDLE.
  - A RWAIT->PRESSED return generates no pulse.
  - key_press and key_release are never high together for the same key.
- key_level is registered from FSM state. It rises in the same cycle as key_press and falls in the same cycle as key_release.
- Latency, raw press to key_press, with stable input: 2 (sync) + 1 (IDLE->PWAIT) + DEBOUNCE_CYCLES edges, i.e. DEBOUNCE_CYCLES+3 edges after the first edge that samples KEY low. Release latency is identical.
- Counter never wraps; it saturates implicitly because the FSM leaves the WAIT state at DEBOUNCE_CYCLES-1.
- Simultaneous presses on multiple keys are processed independently. Pulses may coincide across keys.
- Reset mid-operation: all state returns to reset values immediately and no pulse is emitted in the reset cycle. A key still held after rst drops is re-debounced from IDLE and produces a fresh key_press.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4 for the bench):
- Reset: assert rst 2 cycles with KEY=4'b0000, sw=18'h3FFFF -> key_level=0, key_press=0, key_release=0, sw_sync=0 during reset.
- Clean press: KEY[0] driven 0 from edge 1 and held -> key_press[0]=1 for exactly the cycle after edge 7, key_level[0]=1 from then on. Other keys stay 0.
- Bounce rejection: KEY[1] low for 3 cycles, high 1, low 2, then high -> no key_press[1], key_level[1] stays 0.
- Release with glitch:
  - From PRESSED, KEY[2] goes high 2 cycles then low -> no key_release, key_level[2] stays 1.
  - Then held high -> key_release[2] one cycle, 7 edges after the final rise; key_level[2]=0.
- Simultaneous keys plus reset mid-press:
  - KEY=4'b0000 held -> key_press=4'b1111 in the same cycle.
  - Then pulse rst 1 cycle while held -> key_level=0. key_press=4'b1111 again 7 edges after rst deasserts.
- Switch sync: sw changes 18'h00000 -> 18'h2A5A5 at edge 10 -> sw_sync=18'h2A5A5 from edge 12, unchanged before.
